// File: rtl/seg_scan_dri.sv
// Multiplexed 7-segment scan driver: hex decode, per-digit dp, leading-zero blanking, 16-level duty.
// Optional blink support is compiled in with `define SEG_BLINK_EN (adds blink port and BLINK_DIV).
module seg_scan_dri #(
    parameter int DIG_NUM     = 6,
    parameter int CLK_DIV     = 50_000,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 1
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_DIV   = 250
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [4*DIG_NUM-1:0]   num,
    input  logic [DIG_NUM-1:0]     point,
    input  logic                   lz_en,
    input  logic [3:0]             bright,
`ifdef SEG_BLINK_EN
    input  logic [DIG_NUM-1:0]     blink,
`endif
    output logic [DIG_NUM-1:0]     sel,
    output logic [7:0]             seg_led
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = $clog2(DIG_NUM);
    localparam logic [DIG_NUM-1:0] SEL_OFF = (SEL_ACT_LOW != 0) ? '1 : '0;
    localparam logic [7:0]         SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    // Active-low g..a pattern for one hex digit.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'h0: f_decode = 7'b1000000;
            4'h1: f_decode = 7'b1111001;
            4'h2: f_decode = 7'b0100100;
            4'h3: f_decode = 7'b0110000;
            4'h4: f_decode = 7'b0011001;
            4'h5: f_decode = 7'b0010010;
            4'h6: f_decode = 7'b0000010;
            4'h7: f_decode = 7'b1111000;
            4'h8: f_decode = 7'b0000000;
            4'h9: f_decode = 7'b0010000;
            4'hA: f_decode = 7'b0001000;
            4'hB: f_decode = 7'b0000011;
            4'hC: f_decode = 7'b1000110;
            4'hD: f_decode = 7'b0100001;
            4'hE: f_decode = 7'b0000110;
            default: f_decode = 7'b0001110;
        endcase
    endfunction

    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic                 r_en_d;
    logic [4*DIG_NUM-1:0] r_num;
    logic [DIG_NUM-1:0]   r_point;
    logic                 r_lz;
    logic [3:0]           r_bright;
    logic [DIG_NUM-1:0]   r_sel;
    logic [7:0]           r_seg;

    logic                 w_slot_end;
    logic                 w_last_dig;
    logic                 w_en_rise;
    logic [4*DIG_NUM-1:0] w_num_cur;
    logic [DIG_NUM-1:0]   w_point_cur;
    logic                 w_lz_cur;
    logic [3:0]           w_bright_eff;
    logic [31:0]          w_on_len;
    logic                 w_on;
    logic [3:0]           w_dig;
    logic                 w_dp;
    logic                 w_blank;
    logic                 w_zero_run;
    logic [DIG_NUM-1:0]   w_sel_oh;
    logic [7:0]           w_seg_n;
    logic                 w_blink_dark;

    assign w_slot_end = (r_cnt == CW'(CLK_DIV - 1));
    assign w_last_dig = (r_idx == IW'(DIG_NUM - 1));
    assign w_en_rise  = en & ~r_en_d;

    // On the enable edge the frame registers are still stale, so show the live inputs for that one cycle.
    assign w_num_cur   = w_en_rise ? num   : r_num;
    assign w_point_cur = w_en_rise ? point : r_point;
    assign w_lz_cur    = w_en_rise ? lz_en : r_lz;

    assign w_bright_eff = (r_cnt == '0) ? bright : r_bright;
    assign w_on_len     = ((32'(w_bright_eff) + 32'd1) * 32'(CLK_DIV)) >> 4;
    assign w_on         = (32'(r_cnt) < w_on_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_en_d   <= 1'b0;
            r_num    <= '0;
            r_point  <= '0;
            r_lz     <= 1'b0;
            r_bright <= '0;
        end else begin
            r_en_d <= en;
            if (!en) begin
                r_cnt <= '0;
                r_idx <= '0;
            end else if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= w_last_dig ? '0 : r_idx + IW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_en_rise || (en && w_slot_end && w_last_dig)) begin
                r_num   <= num;
                r_point <= point;
                r_lz    <= lz_en;
            end
            if (en && (r_cnt == '0))
                r_bright <= bright;
        end
    end

    // Walk from the leftmost digit down so w_zero_run means "this digit and all above are zero".
    always_comb begin
        w_dig      = 4'd0;
        w_dp       = 1'b0;
        w_blank    = 1'b0;
        w_sel_oh   = '0;
        w_zero_run = 1'b1;
        for (int i = DIG_NUM - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (w_num_cur[4*i +: 4] == 4'd0);
            if (r_idx == IW'(i)) begin
                w_dig       = w_num_cur[4*i +: 4];
                w_dp        = w_point_cur[i];
                w_blank     = w_lz_cur && (i != 0) && w_zero_run;
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    assign w_seg_n = {~w_dp, (w_blank ? 7'h7F : f_decode(w_dig))};

`ifdef SEG_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    logic [BW-1:0] r_bcnt;
    logic          r_blink_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt      <= '0;
            r_blink_off <= 1'b0;
        end else if (!en) begin
            r_bcnt      <= '0;
            r_blink_off <= 1'b0;
        end else if (w_slot_end) begin
            if (r_bcnt == BW'(BLINK_DIV - 1)) begin
                r_bcnt      <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
            end
        end
    end

    assign w_blink_dark = r_blink_off & (|(blink & w_sel_oh));
`else
    assign w_blink_dark = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= SEL_OFF;
            r_seg <= SEG_OFF;
        end else if (en && w_on) begin
            r_sel <= (SEL_ACT_LOW != 0) ? ~w_sel_oh : w_sel_oh;
            if (w_blink_dark)
                r_seg <= SEG_OFF;
            else
                r_seg <= (SEG_ACT_LOW != 0) ? w_seg_n : ~w_seg_n;
        end else begin
            r_sel <= SEL_OFF;
            r_seg <= SEG_OFF;
        end
    end

    assign sel     = r_sel;
    assign seg_led = r_seg;

endmodule

// File: tb/tb_seg_scan_dri.sv
// Bench for seg_scan_dri (4 digits, 16 clk/slot, active-low pins): directed tables plus
// randomized scan checked against a time-indexed model of frames, slots and duty.
module tb_seg_scan_dri;

    localparam int NDIG = 4;
    localparam int CDIV = 16;
    localparam int BDIV = 2;
    localparam int HMAX = 4096;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] num;
    logic [3:0]  point;
    logic        lz_en;
    logic [3:0]  bright;
    logic [3:0]  sel;
    logic [7:0]  seg_led;
`ifdef SEG_BLINK_EN
    logic [3:0]  cur_bk;
    logic [3:0]  h_bk [HMAX];
`endif

    seg_scan_dri #(
        .DIG_NUM(NDIG), .CLK_DIV(CDIV), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)
`ifdef SEG_BLINK_EN
        , .BLINK_DIV(BDIV)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .num(num), .point(point),
        .lz_en(lz_en), .bright(bright),
`ifdef SEG_BLINK_EN
        .blink(cur_bk),
`endif
        .sel(sel), .seg_led(seg_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int tcur  = 0;
    logic [3:0]  last_sel;
    logic [7:0]  last_seg;

    logic [15:0] h_num [HMAX];
    logic [3:0]  h_pt  [HMAX];
    logic        h_lz  [HMAX];
    logic [3:0]  h_br  [HMAX];

    typedef struct packed {
        logic [15:0] num;
        logic [3:0]  pt;
        logic        lz;
        logic [31:0] seg;   // expected seg_led per digit, digit0 in [7:0]
    } vec_t;

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d: got %h, expected %h", name, t, act, exp);
        end
    endtask

    // Expected pins for enabled cycle t counted from the enable edge.
    function automatic void model(input int t, output logic [3:0] es, output logic [7:0] eg);
        int slot, frame, i, c, src, b;
        logic [15:0] n;
        logic [3:0]  d;
        logic        blank;
        slot  = t / CDIV;
        frame = t / (CDIV * NDIG);
        i     = slot % NDIG;
        c     = t % CDIV;
        src   = (frame == 0) ? 0 : frame * CDIV * NDIG - 1;
        n     = h_num[src];
        b     = int'(h_br[slot * CDIV]);
        es    = 4'hF;
        eg    = 8'hFF;
        if (c < ((b + 1) * CDIV) / 16) begin
            es    = ~(4'b0001 << i);
            d     = 4'(n >> (4 * i));
            blank = h_lz[src] && (i > 0) && ((n >> (4 * i)) == 16'd0);
            eg    = {~h_pt[src][i], (blank ? 7'h7F : SEG_TAB[d])};
`ifdef SEG_BLINK_EN
            if (((slot / BDIV) % 2 == 1) && h_bk[t][i])
                eg = 8'hFF;
`endif
        end
    endfunction

    task automatic step(input logic e, input logic [15:0] n, input logic [3:0] p,
                        input logic lz, input logic [3:0] b);
        logic [3:0] es;
        logic [7:0] eg;
        int t;
        en = e; num = n; point = p; lz_en = lz; bright = b;
        t = tcur;
        if (e) begin
            h_num[t] = n; h_pt[t] = p; h_lz[t] = lz; h_br[t] = b;
`ifdef SEG_BLINK_EN
            h_bk[t] = cur_bk;
`endif
        end
        @(posedge clk);
        #1;
        if (e) model(t, es, eg);
        else begin es = 4'hF; eg = 8'hFF; end
        last_sel = sel;
        last_seg = seg_led;
        chk("scan", t, {20'h0, sel, seg_led}, {20'h0, es, eg});
        tcur = e ? t + 1 : 0;
    endtask

    initial begin
        vec_t        tbl [5];
        logic [3:0]  xs;
        logic [63:0] mid_exp;
        int          cnt_on [4];
        logic [15:0] rn;
        logic [3:0]  rp, rb;
        logic        rl, re;

        tbl[0] = '{16'h1234, 4'b0000, 1'b0, 32'hF9A4B099};
        tbl[1] = '{16'h00A0, 4'b0100, 1'b1, 32'hFF7F88C0};
        tbl[2] = '{16'h00A0, 4'b0100, 1'b0, 32'hC04088C0};
        tbl[3] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0};
        tbl[4] = '{16'hF00E, 4'b1001, 1'b1, 32'h0EC0C006};
        mid_exp = 64'h9282F880F9A4B099;

        rst_n = 1'b0; en = 1'b1; num = 16'h1234; point = 4'h0; lz_en = 1'b0; bright = 4'hF;
`ifdef SEG_BLINK_EN
        cur_bk = 4'b0001;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sel", 0, {28'h0, sel}, 32'hF);
        chk("reset_seg", 0, {24'h0, seg_led}, 32'hFF);
        rst_n = 1'b1;
        tcur  = 0;

        // Static frames from the decode table, observed at each slot start.
        for (int v = 0; v < 5; v++) begin
            step(1'b0, tbl[v].num, tbl[v].pt, tbl[v].lz, 4'hF);
            for (int k = 0; k < 64; k++) begin
                step(1'b1, tbl[v].num, tbl[v].pt, tbl[v].lz, 4'hF);
                if (k % 16 == 0) begin
                    xs = ~(4'b0001 << (k / 16));
                    chk("tbl_sel", k, {28'h0, last_sel}, {28'h0, xs});
                    chk("tbl_seg", k, {24'h0, last_seg}, {24'h0, tbl[v].seg[8*(k/16) +: 8]});
                end
            end
        end

        // Duty: bright=3 -> 4 clk per slot, bright=0 -> 1 clk per slot.
        for (int r = 0; r < 2; r++) begin
            rb = (r == 0) ? 4'd3 : 4'd0;
            for (int s = 0; s < 4; s++) cnt_on[s] = 0;
            step(1'b0, 16'h1234, 4'h0, 1'b0, rb);
            for (int k = 0; k < 64; k++) begin
                step(1'b1, 16'h1234, 4'h0, 1'b0, rb);
                if (last_sel != 4'hF) cnt_on[k / 16]++;
            end
            for (int s = 0; s < 4; s++)
                chk("duty", s, cnt_on[s], (r == 0) ? 32'd4 : 32'd1);
        end

        // num changes mid-frame at idx 1; new digits appear only from the next frame.
        step(1'b0, 16'h1234, 4'h0, 1'b0, 4'hF);
        for (int k = 0; k < 128; k++) begin
            step(1'b1, (k < 20) ? 16'h1234 : 16'h5678, 4'h0, 1'b0, 4'hF);
            if (k % 16 == 0)
                chk("midframe", k, {24'h0, last_seg}, {24'h0, mid_exp[8*(k/16) +: 8]});
        end

        // en dropped at idx 2, then raised: digit 0 first.
        step(1'b0, 16'h1234, 4'h0, 1'b0, 4'hF);
        for (int k = 0; k <= 40; k++) step(1'b1, 16'h1234, 4'h0, 1'b0, 4'hF);
        step(1'b0, 16'h1234, 4'h0, 1'b0, 4'hF);
        chk("en_drop", 0, {20'h0, last_sel, last_seg}, 32'hFFF);
        step(1'b1, 16'h1234, 4'h0, 1'b0, 4'hF);
        chk("en_rise", 0, {20'h0, last_sel, last_seg}, 32'hE99);

        // Asynchronous reset mid-slot: dark without a clock edge, restart at digit 0.
        for (int k = 0; k < 20; k++) step(1'b1, 16'h1234, 4'h0, 1'b0, 4'hF);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 0, {20'h0, sel, seg_led}, 32'hFFF);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tcur = 0;
        step(1'b1, 16'h1234, 4'h0, 1'b0, 4'hF);
        chk("rst_restart", 0, {20'h0, last_sel, last_seg}, 32'hE99);

        // Randomized scan against the model.
        rn = 16'h1234; rp = 4'h0; rl = 1'b0; rb = 4'hF;
        for (int k = 0; k < 3000; k++) begin
            re = !(($urandom_range(0, 149) == 0) || (tcur >= HMAX - 8));
            if ($urandom_range(0, 39) == 0) rn = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 59) == 0) rp = 4'($urandom);
            if ($urandom_range(0, 79) == 0) rl = ~rl;
            if ($urandom_range(0, 9) == 0)  rb = 4'($urandom);
`ifdef SEG_BLINK_EN
            if ($urandom_range(0, 99) == 0) cur_bk = 4'($urandom);
`endif
            step(re, rn, rp, rl, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
